// File: rtl/i2c_reg_bank.sv
// Byte-wide register bank behind the I2C slave register port: per-register
// read/write, read-only (live hardware value) or write-1-to-clear status, with write strobes and irq.
module i2c_reg_bank #(
  parameter int                           NUM_REGS    = 8,
  parameter int                           ADDR_W      = 8,
  parameter int                           DATA_W      = 8,
  parameter logic [NUM_REGS-1:0]          RO_MASK     = {NUM_REGS{1'b0}},
  parameter logic [NUM_REGS-1:0]          W1C_MASK    = {NUM_REGS{1'b0}},
  parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VAL   = {NUM_REGS*DATA_W{1'b0}},
  parameter int                           IRQ_EN_ADDR = NUM_REGS - 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            dataIn,
  input  logic                         writeEn,
  output logic [DATA_W-1:0]            dataOut,
  output logic [NUM_REGS*DATA_W-1:0]   regOut,
  input  logic [NUM_REGS*DATA_W-1:0]   hwIn,
  output logic [NUM_REGS-1:0]          wrStrobe,
  output logic                         irq
);

  // Read-only wins when a register is flagged both read-only and W1C.
  localparam logic [NUM_REGS-1:0] W1C_EFF = W1C_MASK & ~RO_MASK;

  function automatic bit en_is_rw();
    bit r;
    r = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == IRQ_EN_ADDR) r = !RO_MASK[i] && !W1C_MASK[i];
    end
    return r;
  endfunction

  localparam bit EN_IS_RW = en_is_rw();
  localparam int EN_IDX   = EN_IS_RW ? IRQ_EN_ADDR : 0;

  logic [DATA_W-1:0]   regs_q   [NUM_REGS];
  logic [DATA_W-1:0]   regs_d   [NUM_REGS];
  logic [DATA_W-1:0]   cur_val  [NUM_REGS];
  logic [NUM_REGS-1:0] sel;
  logic [DATA_W-1:0]   en_mask;
  logic [DATA_W-1:0]   pending;
  logic [DATA_W-1:0]   data_out_d, data_out_q;
  logic [NUM_REGS-1:0] wr_strobe_d, wr_strobe_q;
  logic                irq_d, irq_q;

  always_comb begin
    sel         = '0;
    data_out_d  = '0;
    pending     = '0;
    regOut      = '0;
    en_mask     = EN_IS_RW ? regs_q[EN_IDX] : {DATA_W{1'b1}};
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i]     = (addr == ADDR_W'(i));
      cur_val[i] = RO_MASK[i] ? hwIn[i*DATA_W +: DATA_W] : regs_q[i];
      regs_d[i]  = regs_q[i];
      if (RO_MASK[i]) begin
        regs_d[i] = regs_q[i];
      end else if (W1C_EFF[i]) begin
        // Hardware set is OR-ed in after the clear so it wins a collision.
        regs_d[i] = (regs_q[i] & ~((writeEn && sel[i]) ? dataIn : '0))
                    | hwIn[i*DATA_W +: DATA_W];
      end else if (writeEn && sel[i]) begin
        regs_d[i] = dataIn;
      end
      if (sel[i]) data_out_d = cur_val[i];
      if (W1C_EFF[i]) pending = pending | (regs_q[i] & en_mask);
      regOut[i*DATA_W +: DATA_W] = cur_val[i];
    end
    wr_strobe_d = writeEn ? sel : '0;
    irq_d       = |pending;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= W1C_EFF[i] ? '0 : RESET_VAL[i*DATA_W +: DATA_W];
      end
      data_out_q  <= '0;
      wr_strobe_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      data_out_q  <= data_out_d;
      wr_strobe_q <= wr_strobe_d;
      irq_q       <= irq_d;
    end
  end

  assign dataOut  = data_out_q;
  assign wrStrobe = wr_strobe_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Randomised and directed bench for i2c_reg_bank against an array-based register model.
module tb_i2c_reg_bank;

  localparam int NR = 8;
  localparam logic [63:0] RST_VAL = 64'h8877_6655_4433_2211;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  addr = '0;
  logic [7:0]  dataIn = '0;
  logic        writeEn = 1'b0;
  logic [7:0]  dataOut;
  logic [63:0] regOut;
  logic [63:0] hwIn = '0;
  logic [7:0]  wrStrobe;
  logic        irq;

  i2c_reg_bank #(
    .NUM_REGS(NR), .ADDR_W(8), .DATA_W(8),
    .RO_MASK(8'h02), .W1C_MASK(8'h0B),
    .RESET_VAL(RST_VAL), .IRQ_EN_ADDR(7)
  ) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .dataIn(dataIn), .writeEn(writeEn),
    .dataOut(dataOut), .regOut(regOut), .hwIn(hwIn), .wrStrobe(wrStrobe), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: reg1 read-only (reads hw slice 1), reg0/reg3 W1C, reg7 is irq enable, rest plain R/W.
  logic [7:0] mem [NR];
  logic [7:0] hw_ro = 8'h00;

  function automatic bit is_ro(int i);  return i == 1;            endfunction
  function automatic bit is_w1c(int i); return i == 0 || i == 3;  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] view(int i, logic [63:0] hw);
    return is_ro(i) ? hw[i*8 +: 8] : mem[i];
  endfunction

  function automatic logic [63:0] model_regout(logic [63:0] hw);
    logic [63:0] r;
    for (int i = 0; i < NR; i++) r[i*8 +: 8] = view(i, hw);
    return r;
  endfunction

  function automatic logic [63:0] mk_hw(logic [7:0] p0, logic [7:0] p3);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[7:0]   = p0;
    h[15:8]  = hw_ro;
    h[31:24] = p3;
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mem[i] = is_w1c(i) ? 8'h00 : RST_VAL[i*8 +: 8];
  endtask

  task automatic cycle(input logic [7:0] a, input logic [7:0] d, input logic we,
                       input logic [7:0] p0, input logic [7:0] p3);
    logic [63:0] hw;
    logic [7:0]  exp_do, exp_st;
    logic        exp_irq;
    int          ai;
    hw = mk_hw(p0, p3);
    ai = int'(a);
    exp_do  = (ai < NR) ? view(ai, hw) : 8'h00;
    exp_st  = (we && ai < NR) ? (8'h01 << ai) : 8'h00;
    exp_irq = |((mem[0] | mem[3]) & mem[7]);
    addr = a; dataIn = d; writeEn = we; hwIn = hw;
    @(posedge clk);
    if (we && ai < NR && !is_ro(ai) && !is_w1c(ai)) mem[ai] = d;
    for (int i = 0; i < NR; i++) begin
      if (is_w1c(i)) mem[i] = (mem[i] & ~((we && ai == i) ? d : 8'h00)) | hw[i*8 +: 8];
    end
    #1;
    chk("dataOut", 64'(dataOut), 64'(exp_do));
    chk("wrStrobe", 64'(wrStrobe), 64'(exp_st));
    chk("irq", 64'(irq), 64'(exp_irq));
    chk("regOut", regOut, model_regout(hw));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    hwIn = mk_hw(8'h00, 8'h00);
    #12;
    chk("rst_dataOut", 64'(dataOut), 64'h0);
    chk("rst_wrStrobe", 64'(wrStrobe), 64'h0);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_regOut", regOut, model_regout(hwIn));
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) cycle(8'(i), 8'h00, 1'b0, 8'h00, 8'h00);
    cycle(8'h04, 8'h00, 1'b0, 8'h00, 8'h00);

    // Read/write and unmapped access
    cycle(8'h02, 8'hA5, 1'b1, 8'h00, 8'h00);
    cycle(8'h09, 8'hFF, 1'b1, 8'h00, 8'h00);
    cycle(8'h02, 8'h00, 1'b0, 8'h00, 8'h00);
    cycle(8'h09, 8'h00, 1'b0, 8'h00, 8'h00);
    cycle(8'h09, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("unmapped_read", 64'(dataOut), 64'h0);

    // Read-only register
    hw_ro = 8'h3C;
    cycle(8'h01, 8'h00, 1'b1, 8'h00, 8'h00);
    cycle(8'h01, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("ro_read_3c", 64'(dataOut), 64'h3C);
    hw_ro = 8'h7E;
    cycle(8'h01, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("ro_read_7e", 64'(dataOut), 64'h7E);

    // W1C collision
    cycle(8'h20, 8'h00, 1'b0, 8'h81, 8'h00);
    cycle(8'h00, 8'h01, 1'b1, 8'h01, 8'h00);
    cycle(8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("w1c_collision", 64'(dataOut), 64'h81);
    cycle(8'h00, 8'h81, 1'b1, 8'h00, 8'h00);
    cycle(8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("w1c_cleared", 64'(dataOut), 64'h00);

    // Interrupt masking
    cycle(8'h07, 8'h80, 1'b1, 8'h00, 8'h00);
    cycle(8'h20, 8'h00, 1'b0, 8'h01, 8'h00);
    cycle(8'h20, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("irq_masked", 64'(irq), 64'h0);
    cycle(8'h07, 8'h81, 1'b1, 8'h00, 8'h00);
    cycle(8'h20, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("irq_enabled", 64'(irq), 64'h1);
    cycle(8'h00, 8'h01, 1'b1, 8'h00, 8'h00);
    cycle(8'h20, 8'h00, 1'b0, 8'h00, 8'h00);
    chk("irq_cleared", 64'(irq), 64'h0);

    // Back-to-back writes
    for (int i = 0; i < 8; i++) cycle(8'(i), 8'(i) ^ 8'h5A, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 9; i++) cycle(8'(i), 8'h00, 1'b0, 8'h00, 8'h00);

    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 15) == 0) hw_ro = 8'($urandom);
      cycle(8'($urandom_range(0, 11)), 8'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end

    // Mid-cycle reset with a write pending and irq raised
    cycle(8'h07, 8'hFF, 1'b1, 8'h00, 8'hFF);
    cycle(8'h05, 8'h66, 1'b1, 8'h00, 8'h00);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_dataOut", 64'(dataOut), 64'h0);
    chk("mid_rst_wrStrobe", 64'(wrStrobe), 64'h0);
    chk("mid_rst_irq", 64'(irq), 64'h0);
    chk("mid_rst_regOut", regOut, model_regout(hwIn));
    addr = 8'h02; dataIn = 8'h77; writeEn = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_write_lost", regOut, model_regout(hwIn));
    #3 rstn = 1'b1;
    cycle(8'h02, 8'h77, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) cycle(8'(i), 8'h00, 1'b0, 8'h00, 8'h00);
    cycle(8'h04, 8'h00, 1'b0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
